iterative_shifter: RTL and testbench

- Multicycle shift unit for the ALU shift path. Applies at most 2 bit positions per clock, so it uses only shift-by-2 and shift-by-1 stages and no full 32-bit barrel.
- Accepts a shift request from decode/execute control and returns the result with a ready pulse.
- Supports logical left, arithmetic right and logical right shifts.

---
 rtl/iterative_shifter.sv | 96 +++++++++
 tb/tb_iterative_shifter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/iterative_shifter.sv
// Multicycle shifter applying at most two bit positions per clock (sll, sra, srl).
// Define SHIFTER_ROTATE_EN to make op 2'b11 a rotate right; otherwise 2'b11 behaves as srl.
module iterative_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               ctrl_start,
    input  logic [1:0]         ctrl_op,
    input  logic [SHAMT_W-1:0] ctrl_shamt,
    input  logic [WIDTH-1:0]   data_operand,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               data_busy
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [SHAMT_W-1:0] OneStep = SHAMT_W'(1);
    localparam logic [SHAMT_W-1:0] TwoStep = SHAMT_W'(2);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [1:0]           op_q, op_d;
    logic [SHAMT_W-1:0]   rem_q, rem_d;
    logic                 step2;
    logic [WIDTH-1:0]     shifted;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            work_q  <= '0;
            op_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
        end
    end

    // One step of the shift schedule: by 2 while at least 2 positions remain, else by 1.
    always_comb begin
        step2   = (rem_q >= TwoStep);
        shifted = work_q;
        unique case (op_q)
            2'b00: shifted = step2 ? {work_q[WIDTH-3:0], 2'b00} : {work_q[WIDTH-2:0], 1'b0};
            2'b01: shifted = step2 ? {{2{work_q[WIDTH-1]}}, work_q[WIDTH-1:2]}
                                   : {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            2'b10: shifted = step2 ? {2'b00, work_q[WIDTH-1:2]} : {1'b0, work_q[WIDTH-1:1]};
            2'b11: begin
`ifdef SHIFTER_ROTATE_EN
                shifted = step2 ? {work_q[1:0], work_q[WIDTH-1:2]}
                                : {work_q[0], work_q[WIDTH-1:1]};
`else
                shifted = step2 ? {2'b00, work_q[WIDTH-1:2]} : {1'b0, work_q[WIDTH-1:1]};
`endif
            end
            default: shifted = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (ctrl_start) begin
                    work_d  = data_operand;
                    op_d    = ctrl_op;
                    rem_d   = ctrl_shamt;
                    state_d = (ctrl_shamt == '0) ? StDone : StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                work_d = shifted;
                rem_d  = rem_q - (step2 ? TwoStep : OneStep);
                if (rem_d == '0) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data_result    = work_q;
    assign data_resultRDY = (state_q == StDone);
    assign data_busy      = (state_q == StShift);

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed self-checking bench for iterative_shifter with hand-computed expected results.
// Honours SHIFTER_ROTATE_EN for the op 2'b11 expectation.
module tb_iterative_shifter;

    logic        clock;
    logic        reset_n;
    logic        ctrl_start;
    logic [1:0]  ctrl_op;
    logic [4:0]  ctrl_shamt;
    logic [31:0] data_operand;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        data_busy;

    int n_checks = 0;
    int n_errors = 0;

    iterative_shifter #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_start     (ctrl_start),
        .ctrl_op        (ctrl_op),
        .ctrl_shamt     (ctrl_shamt),
        .data_operand   (data_operand),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .data_busy      (data_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; request is sampled on the following posedge.
    task automatic drive_start(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] v);
        ctrl_op      = op;
        ctrl_shamt   = sh;
        data_operand = v;
        ctrl_start   = 1'b1;
        @(posedge clock);
        #1;
        ctrl_start   = 1'b0;
        // Scramble inputs: the captured operation must not see these.
        ctrl_op      = ~op;
        ctrl_shamt   = ~sh;
        data_operand = ~v;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [4:0] sh,
                          input logic [31:0] v, input logic [31:0] exp);
        int busy_cnt;
        int cyc;
        bit seen;
        busy_cnt = 0;
        cyc      = 0;
        seen     = 0;
        @(negedge clock);
        drive_start(op, sh, v);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            cyc++;
            if (data_busy) busy_cnt++;
            if (data_resultRDY) seen = 1;
        end
        check_eq({tag, " rdy_seen"}, 32'(seen), 32'd1);
        check_eq({tag, " result"}, data_result, exp);
        check_eq({tag, " busy_cycles"}, 32'(busy_cnt), 32'((sh + 1) / 2));
        check_eq({tag, " latency"}, 32'(cyc), 32'((sh + 1) / 2 + 1));
        @(negedge clock);
        check_eq({tag, " rdy_single"}, 32'(data_resultRDY), 32'd0);
        check_eq({tag, " hold"}, data_result, exp);
    endtask

    initial begin
        int rdy_cnt;
        logic [31:0] rot_exp;

        reset_n      = 1'b0;
        ctrl_start   = 1'b0;
        ctrl_op      = 2'b00;
        ctrl_shamt   = '0;
        data_operand = '0;
        #1;
        check_eq("reset result", data_result, 32'h0);
        check_eq("reset rdy", 32'(data_resultRDY), 32'd0);
        check_eq("reset busy", 32'(data_busy), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        run_op("sra 80000000>>5", 2'b01, 5'd5, 32'h8000_0000, 32'hFC00_0000);
        run_op("sll 1<<31", 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000);
        run_op("srl F0000000>>4", 2'b10, 5'd4, 32'hF000_0000, 32'h0F00_0000);
        run_op("sll sh0", 2'b00, 5'd0, 32'h1234_5678, 32'h1234_5678);
        run_op("sra sh0", 2'b01, 5'd0, 32'h1234_5678, 32'h1234_5678);
        run_op("srl sh0", 2'b10, 5'd0, 32'h1234_5678, 32'h1234_5678);
        run_op("sra pos>>3", 2'b01, 5'd3, 32'h7FFF_FFFF, 32'h0FFF_FFFF);
        run_op("sll A5<<1", 2'b00, 5'd1, 32'hA5A5_A5A5, 32'h4B4B_4B4A);
        run_op("srl msb>>31", 2'b10, 5'd31, 32'h8000_0000, 32'h0000_0001);
        run_op("sra msb>>31", 2'b01, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);

        // Request during SHIFT is dropped; request during DONE is accepted.
        @(negedge clock);
        drive_start(2'b00, 5'd6, 32'h0000_0003);
        @(negedge clock);
        check_eq("b2b busy1", 32'(data_busy), 32'd1);
        @(negedge clock);
        check_eq("b2b busy2", 32'(data_busy), 32'd1);
        drive_start(2'b10, 5'd1, 32'hFFFF_FFFF);
        @(negedge clock);
        check_eq("b2b busy3", 32'(data_busy), 32'd1);
        @(negedge clock);
        check_eq("b2b rdy", 32'(data_resultRDY), 32'd1);
        check_eq("b2b result", data_result, 32'h0000_00C0);
        drive_start(2'b10, 5'd1, 32'h0000_00C0);
        @(negedge clock);
        check_eq("b2b2 busy", 32'(data_busy), 32'd1);
        check_eq("b2b2 no rdy", 32'(data_resultRDY), 32'd0);
        @(negedge clock);
        check_eq("b2b2 rdy", 32'(data_resultRDY), 32'd1);
        check_eq("b2b2 result", data_result, 32'h0000_0060);

        // Reset mid-operation.
        @(negedge clock);
        drive_start(2'b01, 5'd8, 32'hFFFF_0000);
        @(negedge clock);
        @(negedge clock);
        check_eq("rst pre busy", 32'(data_busy), 32'd1);
        check_eq("rst pre result", data_result, 32'hFFFF_C000);
        reset_n = 1'b0;
        #1;
        check_eq("rst result", data_result, 32'h0);
        check_eq("rst busy", 32'(data_busy), 32'd0);
        check_eq("rst rdy", 32'(data_resultRDY), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rdy_cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (data_resultRDY) rdy_cnt++;
        end
        check_eq("rst no rdy", 32'(rdy_cnt), 32'd0);
        run_op("srl after rst", 2'b10, 5'd8, 32'hFFFF_0000, 32'h00FF_FF00);

`ifdef SHIFTER_ROTATE_EN
        rot_exp = 32'h8000_0000;
`else
        rot_exp = 32'h0000_0000;
`endif
        run_op("op11 1 by 1", 2'b11, 5'd1, 32'h0000_0001, rot_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
